// File: rtl/txn_if.sv
// Bundle of command, transaction and result signals between the initiator
// and its environment (upstream command source, responder, watchdog, result sink).
interface txn_if #(
  parameter int ID_W = 4
) ();
  // cmd_valid/cmd_ready: a command moves on any rising edge where both are high.
  // Once cmd_valid rises, the source holds it and keeps cmd_id stable until
  // that edge. cmd_ready does not wait for cmd_valid.
  logic            cmd_valid;
  logic            cmd_ready;
  logic [ID_W-1:0] cmd_id;
  logic            start_transaction;
  logic            complete_transaction;
  logic            req_timeout;
  logic            done_valid;
  logic [ID_W-1:0] done_id;
  logic [1:0]      done_status;
  logic [1:0]      retry_cnt;
  logic            busy;

  modport master (
    input  cmd_valid, cmd_id, complete_transaction, req_timeout,
    output cmd_ready, start_transaction, done_valid, done_id, done_status,
           retry_cnt, busy
  );

  modport slave (
    output cmd_valid, cmd_id, complete_transaction, req_timeout,
    input  cmd_ready, start_transaction, done_valid, done_id, done_status,
           retry_cnt, busy
  );
endinterface

// File: rtl/txn_initiator.sv
// Initiator of the start/complete/timeout handshake: accepts one command at a
// time, retries timed-out attempts after a fixed backoff and reports the result.
module txn_initiator #(
  parameter int ID_W        = 4,
  parameter int MAX_RETRIES = 2,
  parameter int BACKOFF     = 3
) (
  input  logic       clk,
  input  logic       rst,
  txn_if.master      bus,
  output logic [2:0] dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_WAIT    = 3'd2,
    S_BACKOFF = 3'd3,
    S_REPORT  = 3'd4
  } state_t;

  localparam logic [1:0] ST_OK_FIRST = 2'b00;
  localparam logic [1:0] ST_OK_RETRY = 2'b01;
  localparam logic [1:0] ST_FAILED   = 2'b10;
  localparam logic [1:0] RC_MAX      = 2'(MAX_RETRIES);
  localparam int         BO_W        = (BACKOFF > 1) ? $clog2(BACKOFF) : 1;
  localparam logic [BO_W-1:0] BO_LAST = BO_W'(BACKOFF - 1);

  state_t          state_q;
  logic [ID_W-1:0] id_q;
  logic [1:0]      rc_q;
  logic [BO_W-1:0] bo_q;
  logic            ready_q;
  logic            busy_q;
  logic            start_q;
  logic            done_q;
  logic [ID_W-1:0] done_id_q;
  logic [1:0]      done_st_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      id_q      <= '0;
      rc_q      <= '0;
      bo_q      <= '0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      start_q   <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= '0;
      done_st_q <= '0;
    end else begin
      start_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.cmd_valid && ready_q) begin
            id_q    <= bus.cmd_id;
            rc_q    <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            start_q <= 1'b1;
            state_q <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          // A completion that coincides with a timeout still counts as success.
          if (bus.complete_transaction) begin
            done_q    <= 1'b1;
            done_id_q <= id_q;
            done_st_q <= (rc_q == 2'd0) ? ST_OK_FIRST : ST_OK_RETRY;
            state_q   <= S_REPORT;
          end else if (bus.req_timeout) begin
            if (rc_q < RC_MAX) begin
              rc_q    <= rc_q + 2'd1;
              bo_q    <= '0;
              state_q <= S_BACKOFF;
            end else begin
              done_q    <= 1'b1;
              done_id_q <= id_q;
              done_st_q <= ST_FAILED;
              state_q   <= S_REPORT;
            end
          end
        end
        S_BACKOFF: begin
          // Late responses to the abandoned attempt are dropped here.
          if (bo_q == BO_LAST) begin
            start_q <= 1'b1;
            state_q <= S_ISSUE;
          end else begin
            bo_q <= bo_q + 1'b1;
          end
        end
        S_REPORT: begin
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.cmd_ready         = ready_q;
  assign bus.start_transaction = start_q;
  assign bus.done_valid        = done_q;
  assign bus.done_id           = done_id_q;
  assign bus.done_status       = done_st_q;
  assign bus.retry_cnt         = rc_q;
  assign bus.busy              = busy_q;
  assign dbg_state_o           = state_q;

endmodule

// File: tb/tb_txn_initiator.sv
// Bench for txn_initiator: a cycle-indexed timeline of stimulus and expected
// outputs is planned from transaction-level rules, then replayed and compared.
module tb_txn_initiator;
  localparam int ID_W = 4;
  localparam int MAXR = 2;
  localparam int BO   = 3;
  localparam int N    = 8000;

  logic clk = 1'b1;
  always #5 clk = ~clk;

  logic       rst;
  logic [2:0] dbg_state;
  txn_if #(.ID_W(ID_W)) bus ();

  txn_initiator #(.ID_W(ID_W), .MAX_RETRIES(MAXR), .BACKOFF(BO)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus.master),
    .dbg_state_o (dbg_state)
  );

  // stimulus timeline
  logic            s_rst   [N];
  logic            s_valid [N];
  logic [ID_W-1:0] s_id    [N];
  logic            s_cpl   [N];
  logic            s_to    [N];
  // expected-output timeline
  logic            e_start [N];
  logic            e_done  [N];
  logic            e_busy  [N];
  logic [1:0]      e_rc    [N];
  logic [ID_W-1:0] e_id    [N];
  logic [1:0]      e_st    [N];
  logic            obs_start [N];

  int t, ready_from, min_arrive, t_end, cur_c;
  logic [1:0]      cur_rc, cur_st;
  logic [ID_W-1:0] cur_id;
  int last_acc, last_to, last_done;
  int m2_acc, m2_done, m3_to, m3_done, m4_acc, m4_done, m5_done, m6_rst, m9_done;
  int n_checks, n_errors;

  task automatic fill_to(input int upto, input logic busy);
    for (int c = t; c < upto; c++) begin
      e_busy[c] = busy;
      e_rc[c]   = cur_rc;
      e_id[c]   = cur_id;
      e_st[c]   = cur_st;
    end
    if (upto > t) t = upto;
  endtask

  // n_to: attempts that time out before the final one; fin: 0 complete,
  // 1 complete+timeout together, 2 reset in place of the response.
  task automatic plan_txn(input logic [ID_W-1:0] id, input int n_to, input int fin,
                          input int dfix);
    int v, a, s, r, d, k;
    v = ready_from - int'($urandom_range(0, 3));
    if ($urandom_range(0, 1) == 1) v = ready_from + int'($urandom_range(0, 2));
    if (v < min_arrive) v = min_arrive;
    a = (v > ready_from) ? v : ready_from;
    for (int c = v; c <= a; c++) begin
      s_valid[c] = 1'b1;
      s_id[c]    = id;
    end
    fill_to(a + 1, 1'b0);
    last_acc = a;
    cur_rc = 2'd0;
    s = a + 1;
    k = 0;
    forever begin
      d = (dfix > 0) ? dfix : int'($urandom_range(1, 5));
      r = s + d;
      e_start[s] = 1'b1;
      for (int c = s + 1; c < r; c++) begin
        s_cpl[c] = 1'b0;
        s_to[c]  = 1'b0;
      end
      fill_to(r + 1, 1'b1);
      if (k < n_to) begin
        s_to[r]  = 1'b1;
        s_cpl[r] = 1'b0;
        last_to  = r;
        if (k == MAXR) begin
          e_done[r + 1] = 1'b1;
          cur_id = id;
          cur_st = 2'b10;
          fill_to(r + 2, 1'b1);
          ready_from = r + 2;
          min_arrive = a + 1;
          last_done  = r + 1;
          break;
        end
        k++;
        cur_rc = 2'(k);
        s = r + BO + 1;
      end else if (fin == 2) begin
        s_rst[r]     = 1'b1;
        s_cpl[r]     = 1'b1;
        s_cpl[r + 1] = 1'b1;
        cur_rc = 2'd0;
        cur_id = '0;
        cur_st = 2'd0;
        ready_from = r + 1;
        min_arrive = r + 2;
        last_done  = r;
        break;
      end else begin
        s_cpl[r] = 1'b1;
        s_to[r]  = (fin == 1);
        e_done[r + 1] = 1'b1;
        cur_id = id;
        cur_st = (k == 0) ? 2'b00 : 2'b01;
        fill_to(r + 2, 1'b1);
        ready_from = r + 2;
        min_arrive = a + 1;
        last_done  = r + 1;
        break;
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cur_c, act, exp);
    end
  endtask

  function automatic int count_starts(input int from, input int to);
    int n = 0;
    for (int c = from; c <= to; c++) if (obs_start[c] === 1'b1) n++;
    return n;
  endfunction

  initial begin
    n_checks = 0;
    n_errors = 0;
    for (int c = 0; c < N; c++) begin
      s_rst[c]   = 1'b0;
      s_valid[c] = 1'b0;
      s_id[c]    = ID_W'($urandom_range(0, 15));
      s_cpl[c]   = ($urandom_range(0, 3) == 0);
      s_to[c]    = ($urandom_range(0, 3) == 0);
      e_start[c] = 1'b0;
      e_done[c]  = 1'b0;
      obs_start[c] = 1'b0;
    end
    s_rst[0] = 1'b1;
    s_rst[1] = 1'b1;
    cur_rc = 2'd0;
    cur_st = 2'd0;
    cur_id = '0;
    t = 1;
    ready_from = 2;
    min_arrive = 2;
    fill_to(2, 1'b0);

    plan_txn(4'd5, 0, 0, 3);  m2_acc = last_acc; m2_done = last_done;
    plan_txn(4'd3, 1, 0, 0);  m3_to = last_to;   m3_done = last_done;
    plan_txn(4'd7, 3, 0, 0);  m4_acc = last_acc; m4_done = last_done;
    plan_txn(4'd10, 0, 1, 0); m5_done = last_done;
    plan_txn(4'd12, 0, 2, 0); m6_rst = last_done;
    plan_txn(4'd9, 0, 0, 0);  m9_done = last_done;
    for (int i = 0; i < 150; i++) begin
      if (t > N - 100) break;
      plan_txn(ID_W'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
               ($urandom_range(0, 9) == 0) ? 2 : int'($urandom_range(0, 1)), 0);
    end
    fill_to(t + 6, 1'b0);
    t_end = t;

    for (int c = 0; c < t_end; c++) begin
      cur_c = c;
      rst                      = s_rst[c];
      bus.cmd_valid            = s_valid[c];
      bus.cmd_id               = s_id[c];
      bus.complete_transaction = s_cpl[c];
      bus.req_timeout          = s_to[c];
      @(negedge clk);
      obs_start[c] = bus.start_transaction;
      if (c > 0) begin
        chk("start",     32'(bus.start_transaction), 32'(e_start[c]));
        chk("done_vld",  32'(bus.done_valid),        32'(e_done[c]));
        chk("busy",      32'(bus.busy),              32'(e_busy[c]));
        chk("cmd_ready", 32'(bus.cmd_ready),         32'(!e_busy[c]));
        chk("retry_cnt", 32'(bus.retry_cnt),         32'(e_rc[c]));
        chk("done_id",   32'(bus.done_id),           32'(e_id[c]));
        chk("done_st",   32'(bus.done_status),       32'(e_st[c]));
      end
      if (c == 1) begin
        chk("rst_ready", 32'(bus.cmd_ready), 32'd1);
        chk("rst_busy",  32'(bus.busy), 32'd0);
        chk("rst_start", 32'(bus.start_transaction), 32'd0);
        chk("rst_done",  32'(bus.done_valid), 32'd0);
      end
      if (c == m2_acc + 1) chk("t2_first_start", 32'(bus.start_transaction), 32'd1);
      if (c == m2_done) begin
        chk("t2_dv", 32'(bus.done_valid), 32'd1);
        chk("t2_id", 32'(bus.done_id), 32'd5);
        chk("t2_st", 32'(bus.done_status), 32'd0);
        chk("t2_nstart", 32'(count_starts(m2_acc, m2_done)), 32'd1);
      end
      if (c == m3_to + 3) chk("t3_gap_early", 32'(bus.start_transaction), 32'd0);
      if (c == m3_to + 4) chk("t3_gap", 32'(bus.start_transaction), 32'd1);
      if (c == m3_done) begin
        chk("t3_st", 32'(bus.done_status), 32'd1);
        chk("t3_rc", 32'(bus.retry_cnt), 32'd1);
      end
      if (c == m4_done) begin
        chk("t4_st", 32'(bus.done_status), 32'd2);
        chk("t4_rc", 32'(bus.retry_cnt), 32'd2);
        chk("t4_nstart", 32'(count_starts(m4_acc, m4_done)), 32'd3);
      end
      if (c == m5_done) begin
        chk("t5_st", 32'(bus.done_status), 32'd0);
        chk("t5_rc", 32'(bus.retry_cnt), 32'd0);
      end
      if (c == m6_rst + 1 || c == m6_rst + 2) begin
        chk("t6_busy", 32'(bus.busy), 32'd0);
        chk("t6_nodone", 32'(bus.done_valid), 32'd0);
      end
      if (c == m9_done) begin
        chk("t6_next_id", 32'(bus.done_id), 32'd9);
        chk("t6_next_st", 32'(bus.done_status), 32'd0);
      end
      @(posedge clk);
      #1;
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
